serial_shift_left: RTL and testbench

- Multi-cycle left shifter, one bit position per clock: the opposite direction to the arithmetic right shift (`>>>`) used across the signed-arithmetic regression designs.
- Performs `<<<` / `<<`; both produce the same bit pattern.
- Flags overflow under either signed or unsigned interpretation, selected per operation.
- Sits behind a valid/ready operand port and in front of a valid/ready result port; used as a formal-checkable reference for signed-width rules.

---
 rtl/serial_shift_left.sv | 119 +++++++++++
 tb/tb_serial_shift_left.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_shift_left.sv
// Multi-cycle left shifter: one bit position per clock, with sticky signed/unsigned
// overflow detection, behind valid/ready operand and result ports.
module serial_shift_left #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amount,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_ovf_q, res_ovf_d;
  logic             step_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      ovf_q     <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sgn_q     <= sgn_d;
      ovf_q     <= ovf_d;
      res_q     <= res_d;
      res_ovf_q <= res_ovf_d;
    end
  end

  // Overflow for this step is judged on the accumulator before it shifts.
  always_comb begin
    if (sgn_q) begin
      step_ovf = acc_q[WIDTH-1] ^ acc_q[WIDTH-2];
    end else begin
      step_ovf = acc_q[WIDTH-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sgn_d     = sgn_q;
    ovf_d     = ovf_q;
    res_d     = res_q;
    res_ovf_d = res_ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = in_amount;
          sgn_d   = in_signed;
          ovf_d   = 1'b0;
          state_d = (in_amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        acc_d = {acc_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - SHW'(1);
        ovf_d = ovf_q | step_ovf;
        if (cnt_q == SHW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          res_d     = acc_q;
          res_ovf_d = ovf_q;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outside DONE the accumulator may be mid-shift, so show the last delivered result.
  always_comb begin
    if (state_q == DONE) begin
      out_data     = acc_q;
      out_overflow = ovf_q;
    end else begin
      out_data     = res_q;
      out_overflow = res_ovf_q;
    end
  end

endmodule

// File: tb/tb_serial_shift_left.sv
// Directed bench for serial_shift_left: arithmetic reference model, per-cycle
// output comparison, latency/backpressure/reset checks.
module tb_serial_shift_left;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned SHW   = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amount;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_overflow;

  int errors = 0;
  int checks = 0;

  logic [32:0]      exp_q[$];
  logic [WIDTH-1:0] last_res;

  serial_shift_left #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_amount    (in_amount),
    .in_signed    (in_signed),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_overflow (out_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mathematical reference: value * 2**n, overflow when the exact product does not fit.
  function automatic logic [32:0] model(input logic [31:0] d, input int unsigned n, input logic s);
    logic [63:0]        u;
    logic signed [63:0] p;
    logic signed [63:0] r;
    logic               ovf;
    u = {32'b0, d} << n;
    if (s) begin
      p   = {{32{d[31]}}, d} <<< n;
      r   = {{32{u[31]}}, u[31:0]};
      ovf = (p != r);
    end else begin
      ovf = (u[63:32] != 32'b0);
    end
    return {ovf, u[31:0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          chk("cmp_data", 64'(out_data), 64'(exp_q[0][31:0]));
          chk("cmp_ovf", 64'(out_overflow), 64'(exp_q[0][32]));
          if (out_ready) begin
            last_res = exp_q[0][31:0];
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("idle_data", 64'(out_data), 64'(last_res));
      end
    end
  end

  task automatic do_op(input logic [31:0] d, input int unsigned n, input logic s,
                       input int unsigned hold, input bit lit,
                       input logic [31:0] ed, input logic eo);
    logic [32:0] m;
    int          edges;
    logic [31:0] cap_d;
    logic        cap_o;
    m = model(d, n, s);
    if (lit) begin
      chk("model_data", 64'(m[31:0]), 64'(ed));
      chk("model_ovf", 64'(m[32]), 64'(eo));
    end
    edges = 0;
    while (!in_ready && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("in_ready_before", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = SHW'(n);
    in_signed = s;
    exp_q.push_back(m);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_data   = ~d;
    in_amount = ~SHW'(n);
    in_signed = ~s;
    edges = 0;
    if (!out_valid) in_valid = 1'b1;
    while (!out_valid && edges < 100) begin
      chk("busy_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk("latency", 64'(edges), 64'(n));
    chk("done_valid", 64'(out_valid), 64'd1);
    if (lit) begin
      chk("lit_data", 64'(out_data), 64'(ed));
      chk("lit_ovf", 64'(out_overflow), 64'(eo));
    end
    cap_d = out_data;
    cap_o = out_overflow;
    for (int k = 0; k < int'(hold); k++) begin
      @(posedge clk); #1;
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_data", 64'(out_data), 64'(cap_d));
      chk("hold_ovf", 64'(out_overflow), 64'(cap_o));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("after_valid", 64'(out_valid), 64'd0);
    chk("after_in_ready", 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [31:0] d;
    int unsigned n;
    logic        s;
    int unsigned hold;
    logic [31:0] ed;
    logic        eo;
  } vec_t;

  vec_t vecs[] = '{
    '{32'h0000_0003,  4, 1'b0, 0, 32'h0000_0030, 1'b0},
    '{32'hFFFF_FFFF,  1, 1'b1, 0, 32'hFFFF_FFFE, 1'b0},
    '{32'hFFFF_FFFF,  1, 1'b0, 0, 32'hFFFF_FFFE, 1'b1},
    '{32'h4000_0000,  1, 1'b1, 3, 32'h8000_0000, 1'b1},
    '{32'h4000_0000,  1, 1'b0, 0, 32'h8000_0000, 1'b0},
    '{32'h0000_0001,  0, 1'b0, 0, 32'h0000_0001, 1'b0},
    '{32'h0000_0002, 31, 1'b0, 0, 32'h0000_0000, 1'b1},
    '{32'h0000_0002, 31, 1'b1, 2, 32'h0000_0000, 1'b1},
    '{32'h0000_0000, 31, 1'b1, 0, 32'h0000_0000, 1'b0},
    '{32'h0000_0000, 31, 1'b0, 0, 32'h0000_0000, 1'b0},
    '{32'h0000_FFFF, 16, 1'b1, 0, 32'hFFFF_0000, 1'b1},
    '{32'hC000_0001,  1, 1'b1, 0, 32'h8000_0002, 1'b0},
    '{32'h1234_5678,  8, 1'b0, 1, 32'h3456_7800, 1'b1},
    '{32'h00AB_CDEF,  8, 1'b1, 0, 32'hABCD_EF00, 1'b1},
    '{32'hFFFF_8000, 16, 1'b1, 0, 32'h8000_0000, 1'b0},
    '{32'hFFFF_8000, 16, 1'b0, 0, 32'h8000_0000, 1'b1}
  };

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amount = '0;
    in_signed = 1'b0;
    out_ready = 1'b0;
    last_res  = '0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_overflow), 64'd0);
    #21;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      do_op(vecs[i].d, vecs[i].n, vecs[i].s, vecs[i].hold, 1'b1, vecs[i].ed, vecs[i].eo);
    end

    for (int i = 0; i < 8; i++) begin
      do_op($urandom, $urandom_range(31, 0), 1'($urandom_range(1, 0)), 0, 1'b0, '0, 1'b0);
    end

    // Reset while shifting.
    in_valid  = 1'b1;
    in_data   = 32'h0000_00FF;
    in_amount = SHW'(20);
    in_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_data", 64'(out_data), 64'd0);
    chk("mid_rst_out_ovf", 64'(out_overflow), 64'd0);
    exp_q.delete();
    last_res = '0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (25) begin
      chk("post_rst_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    do_op(32'h0000_0005, 2, 1'b0, 0, 1'b1, 32'h0000_0014, 1'b0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
